bus_rr_interconnect: RTL



---
 rtl/bus_rr_interconnect.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bus_rr_interconnect.sv
// Single-outstanding bus interconnect: round-robin host arbitration, address decode with
// decode-error responses, and a per-transaction device response timeout.
module bus_rr_interconnect #(
  parameter int unsigned NrHosts       = 2,
  parameter int unsigned NrDevices     = 8,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NrHosts-1:0]                       host_req_i,
  output logic [NrHosts-1:0]                       host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
  input  logic [NrHosts-1:0]                       host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
  output logic [NrHosts-1:0]                       host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
  output logic [NrHosts-1:0]                       host_err_o,
  output logic [NrDevices-1:0]                     device_req_o,
  output logic [AddressWidth-1:0]                  device_addr_o,
  output logic                                     device_we_o,
  output logic [DataWidth/8-1:0]                   device_be_o,
  output logic [DataWidth-1:0]                     device_wdata_o,
  input  logic [NrDevices-1:0]                     device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
  input  logic [NrDevices-1:0]                     device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask_i,
  output logic [15:0]                              timeout_count_o,
  output logic [15:0]                              decerr_count_o
);

  localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int unsigned CntW     = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q;
  logic [HostIdxW-1:0]    last_grant_q, owner_q;
  logic [DevIdxW-1:0]     dev_q;
  logic [CntW-1:0]        wait_cnt_q;
  logic [NrHosts-1:0]     rvalid_q, err_q;
  logic [DataWidth-1:0]   rdata_q;
  logic [15:0]            timeout_cnt_q, decerr_cnt_q;

  logic                   gnt_valid, grant, dec_hit;
  logic [HostIdxW-1:0]    gnt_idx, cand;
  logic [DevIdxW-1:0]     dec_idx;

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NrHosts; i++) begin
      cand = HostIdxW'((32'(last_grant_q) + i) % NrHosts);
      if (!gnt_valid && host_req_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant = (state_q == StIdle) && gnt_valid && !rst_i;

  always_comb begin
    host_gnt_o = '0;
    if (grant) host_gnt_o[gnt_idx] = 1'b1;
  end

  assign device_addr_o  = host_addr_i[gnt_idx];
  assign device_we_o    = host_we_i[gnt_idx];
  assign device_be_o    = host_be_i[gnt_idx];
  assign device_wdata_o = host_wdata_i[gnt_idx];

  // Lowest-numbered matching device wins on overlapping regions.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      if (!dec_hit &&
          ((device_addr_o & cfg_device_addr_mask_i[d]) == cfg_device_addr_base_i[d])) begin
        dec_hit = 1'b1;
        dec_idx = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    device_req_o = '0;
    if (grant && dec_hit) device_req_o[dec_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      last_grant_q  <= HostIdxW'(NrHosts - 1);
      owner_q       <= '0;
      dev_q         <= '0;
      wait_cnt_q    <= '0;
      rvalid_q      <= '0;
      err_q         <= '0;
      rdata_q       <= '0;
      timeout_cnt_q <= '0;
      decerr_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            owner_q      <= gnt_idx;
            last_grant_q <= gnt_idx;
            if (dec_hit) begin
              dev_q      <= dec_idx;
              wait_cnt_q <= '0;
              state_q    <= StWait;
            end else begin
              rvalid_q[gnt_idx] <= 1'b1;
              err_q[gnt_idx]    <= 1'b1;
              rdata_q           <= '0;
              if (decerr_cnt_q != 16'hFFFF) decerr_cnt_q <= decerr_cnt_q + 16'd1;
              state_q           <= StResp;
            end
          end
        end
        StWait: begin
          // A response on the last allowed cycle takes priority over the timeout.
          if (device_rvalid_i[dev_q]) begin
            rvalid_q[owner_q] <= 1'b1;
            err_q[owner_q]    <= device_err_i[dev_q];
            rdata_q           <= device_rdata_i[dev_q];
            state_q           <= StResp;
          end else if ((TimeoutCycles != 0) && (wait_cnt_q == CntMax)) begin
            rvalid_q[owner_q] <= 1'b1;
            err_q[owner_q]    <= 1'b1;
            rdata_q           <= '0;
            if (timeout_cnt_q != 16'hFFFF) timeout_cnt_q <= timeout_cnt_q + 16'd1;
            state_q           <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StResp: begin
          rvalid_q <= '0;
          err_q    <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) host_rdata_o[h] = rdata_q;
  end

  assign host_rvalid_o   = rvalid_q;
  assign host_err_o      = err_q;
  assign timeout_count_o = timeout_cnt_q;
  assign decerr_count_o  = decerr_cnt_q;

endmodule
